// File: rtl/ddr_bram_arb.sv
// ddr_bram_arb: two-port round-robin arbiter in front of one single-port, byte-writable BRAM.
// Build option DDR_BRAM_ARB_RDATA_REG_EN re-registers rdata_o/rvalid_o (read latency grant+2).
module ddr_bram_arb #(
  parameter int BRAM_SIZE  = 16,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   req_i,
  input  logic [1:0][BYTE_WIDTH-1:0]   we_i,
  input  logic [1:0][BRAM_SIZE-4:0]    addr_i,
  input  logic [1:0][BYTE_WIDTH*8-1:0] wdata_i,
  output logic [1:0]                   gnt_o,
  output logic [1:0]                   rvalid_o,
  output logic [BYTE_WIDTH*8-1:0]      rdata_o,
  output logic                         ram_en,
  output logic [BYTE_WIDTH-1:0]        ram_we,
  output logic [BRAM_SIZE-4:0]         ram_addr,
  output logic [BYTE_WIDTH*8-1:0]      ram_wrdata,
  input  logic [BYTE_WIDTH*8-1:0]      ram_rddata
);

  localparam int DW = BYTE_WIDTH * 8;

  logic          prio_r;     // port that wins the next contention
  logic [1:0]    gnt_s;
  logic          sel_s;
  logic          rd_s;
  logic [1:0]    rd_pend_r;  // one-hot owner of the read whose data arrives this cycle
  logic [1:0]    rvalid_s;
  logic [DW-1:0] rdata_s;

  // Grant decode: lone requester wins at once, contention goes to prio_r.
  always_comb begin
    gnt_s = 2'b00;
    if (!rst_ni) begin
      gnt_s = 2'b00;
    end else begin
      case (req_i)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = prio_r ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  assign gnt_o = gnt_s;
  assign sel_s = gnt_s[1];

  // RAM command mux: enable and strobes only in a granted cycle.
  always_comb begin
    ram_en     = 1'b0;
    ram_we     = {BYTE_WIDTH{1'b0}};
    ram_addr   = addr_i[sel_s];
    ram_wrdata = wdata_i[sel_s];
    if (gnt_s != 2'b00) begin
      ram_en = 1'b1;
      ram_we = we_i[sel_s];
    end else begin
      ram_en = 1'b0;
      ram_we = {BYTE_WIDTH{1'b0}};
    end
  end

  assign rd_s = ram_en && (ram_we == {BYTE_WIDTH{1'b0}});

  // Round-robin pointer: after a grant, favour the other port.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_r <= 1'b0;
    end else if (gnt_s != 2'b00) begin
      prio_r <= ~sel_s;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Read tracking: remember which port owns the data the RAM returns next cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_pend_r <= 2'b00;
    end else if (rd_s) begin
      rd_pend_r <= gnt_s;
    end else begin
      rd_pend_r <= 2'b00;
    end
  end

`ifdef DDR_BRAM_ARB_RDATA_REG_EN
  logic [1:0]    rvalid_q_r;
  logic [DW-1:0] rdata_q_r;

  // Extra output stage on read data; still one result per cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q_r <= 2'b00;
      rdata_q_r  <= {DW{1'b0}};
    end else begin
      rvalid_q_r <= rd_pend_r;
      rdata_q_r  <= (rd_pend_r != 2'b00) ? ram_rddata : {DW{1'b0}};
    end
  end

  assign rvalid_s = rvalid_q_r;
  assign rdata_s  = rdata_q_r;
`else
  assign rvalid_s = rd_pend_r;
  assign rdata_s  = (rd_pend_r != 2'b00) ? ram_rddata : {DW{1'b0}};
`endif

  // Reset masks a read already in flight so it never surfaces as a pulse.
  assign rvalid_o = rst_ni ? rvalid_s : 2'b00;
  assign rdata_o  = rst_ni ? rdata_s : {DW{1'b0}};

endmodule

// File: tb/tb_ddr_bram_arb.sv
// Self-checking bench for ddr_bram_arb: behavioural BRAM, shadow memory and an rvalid scoreboard.
module tb_ddr_bram_arb;

  localparam int BRAM_SIZE  = 16;
  localparam int BYTE_WIDTH = 8;
  localparam int AW         = BRAM_SIZE - 3;
  localparam int DW         = BYTE_WIDTH * 8;
  localparam int DEPTH      = 1 << AW;
`ifdef DDR_BRAM_ARB_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int            due;
    logic [1:0]    vld;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]                 req;
  logic [1:0][BYTE_WIDTH-1:0] we;
  logic [1:0][AW-1:0]         addr;
  logic [1:0][DW-1:0]         wdata;
  logic [1:0]                 gnt;
  logic [1:0]                 rvalid;
  logic [DW-1:0]              rdata;
  logic                       ram_en;
  logic [BYTE_WIDTH-1:0]      ram_we;
  logic [AW-1:0]              ram_addr;
  logic [DW-1:0]              ram_wrdata;
  logic [DW-1:0]              ram_rddata;

  logic [DW-1:0] ram_mem [0:DEPTH-1];
  logic [DW-1:0] sh_mem  [0:DEPTH-1];
  exp_t          sb_q[$];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [1:0]    mon_vld;
  logic [DW-1:0] mon_data;

  ddr_bram_arb #(.BRAM_SIZE(BRAM_SIZE), .BYTE_WIDTH(BYTE_WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wrdata(ram_wrdata),
    .ram_rddata(ram_rddata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BRAM: byte-write, registered read on enabled reads.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < BYTE_WIDTH; b++)
        if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wrdata[b*8 +: 8];
      if (ram_we == '0) ram_rddata <= ram_mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic exp_read(input int p, input logic [AW-1:0] a);
    exp_t e;
    e.due  = cyc + LAT;
    e.vld  = (p == 0) ? 2'b01 : 2'b10;
    e.data = sh_mem[a];
    sb_q.push_back(e);
  endtask

  task automatic sh_write(input logic [AW-1:0] a, input logic [BYTE_WIDTH-1:0] m, input logic [DW-1:0] d);
    for (int b = 0; b < BYTE_WIDTH; b++)
      if (m[b]) sh_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every cycle rvalid/rdata must match the due entry, or be zero.
  always @(negedge clk) begin
    if (cyc > 0) begin
      mon_vld  = 2'b00;
      mon_data = '0;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        mon_vld  = sb_q[0].vld;
        mon_data = sb_q[0].data;
        void'(sb_q.pop_front());
      end
      check_eq("rvalid", {62'd0, rvalid}, {62'd0, mon_vld});
      check_eq("rdata", rdata, mon_data);
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
      sh_mem[i]  = 64'hC0DE_0000_0000_0000 | 64'(i);
    end
    ram_mem[16'h10] = 64'hDEAD_BEEF_0000_0001;
    sh_mem[16'h10]  = 64'hDEAD_BEEF_0000_0001;
    rst_n = 1'b0;
    req   = 2'b00;
    we    = '0;
    addr  = '0;
    wdata = '0;

    // Reset: requests are ignored, RAM idle.
    next_cycle();
    req  = 2'b11;
    addr = {13'h21, 13'h20};
    @(negedge clk);
    check_eq("rst_gnt", {62'd0, gnt}, 64'd0);
    check_eq("rst_ram_en", {63'd0, ram_en}, 64'd0);
    check_eq("rst_ram_we", {56'd0, ram_we}, 64'd0);
    next_cycle();
    rst_n = 1'b1;

    // Continuous contention from reset alternates starting at port 0.
    for (int k = 0; k < 6; k++) begin
      exp_read(k % 2, (k % 2 == 0) ? 13'h20 : 13'h21);
      @(negedge clk);
      check_eq("rr_gnt", {62'd0, gnt}, (k % 2 == 0) ? 64'd1 : 64'd2);
      check_eq("rr_addr", {51'd0, ram_addr}, (k % 2 == 0) ? 64'h20 : 64'h21);
      next_cycle();
    end
    req = 2'b00;
    next_cycle();

    // Port 0 alone reads 0x10.
    req     = 2'b01;
    we[0]   = 8'h00;
    addr[0] = 13'h10;
    exp_read(0, 13'h10);
    @(negedge clk);
    check_eq("p0_gnt", {62'd0, gnt}, 64'd1);
    check_eq("p0_ram_en", {63'd0, ram_en}, 64'd1);
    next_cycle();

    // Port 1 partial write to 5, then port 0 reads it back next cycle.
    req      = 2'b10;
    we[1]    = 8'h0F;
    addr[1]  = 13'h5;
    wdata[1] = 64'h1122_3344_AABB_CCDD;
    sh_write(13'h5, 8'h0F, 64'h1122_3344_AABB_CCDD);
    @(negedge clk);
    check_eq("wr_gnt", {62'd0, gnt}, 64'd2);
    check_eq("wr_ram_we", {56'd0, ram_we}, 64'h0F);
    check_eq("wr_wrdata", ram_wrdata, 64'h1122_3344_AABB_CCDD);
    next_cycle();
    req     = 2'b01;
    we[1]   = 8'h00;
    addr[0] = 13'h5;
    exp_read(0, 13'h5);
    @(negedge clk);
    check_eq("raw_gnt", {62'd0, gnt}, 64'd1);
    check_eq("raw_shadow", sh_mem[5], 64'hC0DE_0000_AABB_CCDD);
    next_cycle();

    // Four back-to-back port 1 reads of 0..3.
    req = 2'b10;
    for (int k = 0; k < 4; k++) begin
      addr[1] = 13'(k);
      exp_read(1, 13'(k));
      @(negedge clk);
      check_eq("b2b_gnt", {62'd0, gnt}, 64'd2);
      next_cycle();
    end
    req = 2'b00;
    repeat (3) next_cycle();

    // Port 0 read granted, then reset: no rvalid, pointer back to port 0.
    req     = 2'b01;
    addr[0] = 13'h10;
    @(negedge clk);
    check_eq("fl_gnt", {62'd0, gnt}, 64'd1);
    next_cycle();
    rst_n   = 1'b0;
    req     = 2'b11;
    addr[0] = 13'h20;
    addr[1] = 13'h21;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("fl_ram_en", {63'd0, ram_en}, 64'd0);
      check_eq("fl_gnt_rst", {62'd0, gnt}, 64'd0);
      next_cycle();
    end
    rst_n = 1'b1;
    exp_read(0, 13'h20);
    @(negedge clk);
    check_eq("post_rst_gnt", {62'd0, gnt}, 64'd1);
    next_cycle();
    req = 2'b00;

    repeat (4) next_cycle();
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
